bcd_converter_seq: RTL



---
 rtl/dav_display_pkg.sv | 25 ++
 rtl/bcd_converter_seq_if.sv | 23 ++
 rtl/dd_digit_adjust.sv | 20 ++
 rtl/bcd_converter_seq.sv | 106 ++++++++++
 4 files changed

// File: rtl/dav_display_pkg.sv
// Shared types and constants for the display path: BCD digit type, digit count,
// converter state encoding and a power-of-ten helper for parameter checks.
package dav_display_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int NUM_DISPLAY_DIGITS = 6;
    localparam bcd_digit_t BCD_NINE = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_e;

    function automatic longint unsigned pow10(input int n);
        longint unsigned acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage

// File: rtl/bcd_converter_seq_if.sv
// Start/busy/done handshake and result bus between a requester and the
// sequential binary-to-BCD converter.
interface bcd_converter_seq_if #(
    parameter int IN_WIDTH   = 20,
    parameter int NUM_DIGITS = 6
);
    logic                    start;
    logic [IN_WIDTH-1:0]     value;
    logic                    busy;
    logic                    done;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    overflow;

    modport master (
        output start, value,
        input  busy, done, digits, overflow
    );

    modport slave (
        input  start, value,
        output busy, done, digits, overflow
    );
endinterface

// File: rtl/dd_digit_adjust.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module dd_digit_adjust
    import dav_display_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);

    // Add-3 correction, no carry out of the digit
    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end else begin
            adjusted = digit;
        end
    end

endmodule

// File: rtl/bcd_converter_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per cycle, with
// saturating output and an overflow flag when the value exceeds the display.
module bcd_converter_seq
    import dav_display_pkg::*;
#(
    parameter int IN_WIDTH   = 20,
    parameter int NUM_DIGITS = NUM_DISPLAY_DIGITS,
    parameter int SCR_DIGITS = NUM_DIGITS + 1
) (
    input  logic                clk,
    input  logic                reset,
    bcd_converter_seq_if.slave  bus
);

    localparam int SCR_W = 4 * SCR_DIGITS;
    localparam int OUT_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    if (((64'd1 << IN_WIDTH) - 64'd1) >= pow10(SCR_DIGITS)) begin : g_param_check
        $error("bcd_converter_seq: scratch digits too few for IN_WIDTH");
    end

    bcd_state_e              state_r;
    logic [IN_WIDTH-1:0]     shift_r;
    logic [SCR_W-1:0]        scratch_r;
    logic [CNT_W-1:0]        count_r;
    logic                    busy_r;
    logic                    done_r;
    logic [OUT_W-1:0]        digits_r;
    logic                    overflow_r;

    logic [SCR_W-1:0]          adjusted_s;
    logic [SCR_W+IN_WIDTH-1:0] shifted_s;

    for (genvar g = 0; g < SCR_DIGITS; g++) begin : g_adjust
        dd_digit_adjust u_adjust (
            .digit    (scratch_r[4*g +: 4]),
            .adjusted (adjusted_s[4*g +: 4])
        );
    end

    // The top scratch digit can never reach 5 for legal parameters, so its MSB is lost safely
    assign shifted_s = {adjusted_s, shift_r} << 1;

    // Conversion sequencer and registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            shift_r    <= '0;
            scratch_r  <= '0;
            count_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            digits_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        shift_r   <= bus.value;
                        scratch_r <= '0;
                        count_r   <= CNT_W'(IN_WIDTH);
                        busy_r    <= 1'b1;
                        state_r   <= SHIFT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SHIFT: begin
                    {scratch_r, shift_r} <= shifted_s;
                    count_r <= count_r - CNT_W'(1);
                    if (count_r == CNT_W'(1)) begin
                        state_r <= FINISH;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                FINISH: begin
                    // A nonzero extra digit means the value does not fit the display: saturate
                    if (scratch_r[SCR_W-1 -: 4] != 4'd0) begin
                        digits_r   <= {NUM_DIGITS{BCD_NINE}};
                        overflow_r <= 1'b1;
                    end else begin
                        digits_r   <= scratch_r[OUT_W-1:0];
                        overflow_r <= 1'b0;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.digits   = digits_r;
    assign bus.overflow = overflow_r;

endmodule
